// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of the UART receiver.
// master = the receiver itself, slave = the byte consumer / line driver.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rxd,
    output data,
    output valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output rxd,
    input  data,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver for LSB-first 8-bit frames.
// Frame: start(0), 8 data bits, optional even parity, stop(1).
// Define UART_RX_PARITY_EN to receive 11-bit frames with even parity;
// leave it undefined for 10-bit frames with parity_err tied low.
//
// state  | meaning
// IDLE   | line idle, oversample counters held at 0, waiting for 1->0 edge
// START  | confirming start bit by majority vote at its middle
// DATA   | sampling the 8 data bits, shifted in at the MSB
// PARITY | sampling the even-parity bit (only with UART_RX_PARITY_EN)
// STOP   | sampling the stop bit; byte and flags delivered on the decision
// BREAK  | stop bit was 0; waiting for the line to return high
module uart_rx #(
  parameter int DIV = 326
) (
  input  logic      clk_50M,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;
`endif

  state_t state_q, state_d;

  // input conditioning
  logic          rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [1:0]    flush_q, flush_d;
  logic          rxd_sync;
  logic          armed;
  logic          start_edge;

  // oversampling
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]    bit_tick_q, bit_tick_d;
  logic [1:0]    samp_hist_q, samp_hist_d;
  logic          tick;
  logic          decide;
  logic          bit_val;

  // frame assembly and outputs
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic          par_err_q, par_err_d;
  logic          parity_err_q, parity_err_d;
`endif

  assign rxd_sync = rxd_s2_q;

  // The synchronizer resets to 1, so its first cycles after reset can show
  // a fake 1->0 step when rxd is held low; edges are ignored until the
  // chain holds only real line samples.
  assign armed      = (flush_q == 2'd3);
  assign start_edge = armed && !rxd_sync && rxd_prev_q;

  assign tick    = (div_cnt_q == DIV_LAST);
  assign decide  = tick && (bit_tick_q == 4'd9);
  // samples from ticks 7 and 8 are in the history, tick 9 is the live one
  assign bit_val = (samp_hist_q[1] & samp_hist_q[0]) |
                   (samp_hist_q[1] & rxd_sync)       |
                   (samp_hist_q[0] & rxd_sync);

  // two-flop synchronizer plus one-cycle-old copy for edge detection
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      flush_q    <= 2'd0;
    end else begin
      rxd_s1_q   <= bus.rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      flush_q    <= flush_d;
    end
  end

  // count cycles since reset until the synchronizer chain is flushed
  always_comb begin
    flush_d = flush_q;
    if (flush_q != 2'd3) flush_d = flush_q + 2'd1;
  end

  // FSM state register
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_edge) state_d = S_START;
      S_START:  if (decide) state_d = bit_val ? S_IDLE : S_DATA;
      S_DATA: begin
        if (decide && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (decide) state_d = S_STOP;
`endif
      S_STOP:   if (decide) state_d = bit_val ? S_IDLE : S_BREAK;
      S_BREAK:  if (rxd_sync) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: oversample counters, shift register and delivered byte
  always_comb begin
    div_cnt_d   = div_cnt_q;
    bit_tick_d  = bit_tick_q;
    samp_hist_d = samp_hist_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = parity_err_q;
`endif

    if (state_q == S_IDLE) begin
      div_cnt_d  = start_edge ? DW'(1) : '0;
      bit_tick_d = 4'd0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
      if (tick) bit_tick_d = bit_tick_q + 4'd1;
    end

    if (tick) samp_hist_d = {samp_hist_q[0], rxd_sync};

    case (state_q)
      S_START: begin
        // the 16-tick wrap already lands on the next bit's tick 0,
        // so restarting the bit index is all the realignment needed
        if (decide) bit_idx_d = 3'd0;
      end
      S_DATA: begin
        if (decide) begin
          shift_d = {bit_val, shift_q[7:1]};
          if (bit_idx_q != 3'd7) bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (decide) par_err_d = ^{shift_q, bit_val};
      end
`endif
      S_STOP: begin
        if (decide) begin
          data_d      = shift_q;
          valid_d     = 1'b1;
          frame_err_d = !bit_val;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_err_q;
`endif
        end
      end
      default: begin
      end
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      bit_tick_q  <= 4'd0;
      samp_hist_q <= 2'b11;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      div_cnt_q   <= div_cnt_d;
      bit_tick_q  <= bit_tick_d;
      samp_hist_q <= samp_hist_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, hand-written and random frames for uart_rx.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  localparam int DIV  = 4;
  localparam int BITC = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS = PAR_EN ? 11 : 10;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_t;

  typedef struct {
    logic [7:0] b;
    bit         par_bad;
    bit         stop;
    int         glitch;
    int         low_bits;
    int         gap_bits;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  logic clk_50M = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  rx_t  got_q[$];
  logic valid_prev = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.DIV(DIV)) dut (
    .clk_50M (clk_50M),
    .reset   (reset),
    .bus     (bus)
  );

  always #10 clk_50M = ~clk_50M;

  // collect delivered bytes; valid must never last two cycles
  always @(negedge clk_50M) begin
    rx_t r;
    if (bus.valid === 1'b1) begin
      r.data = bus.data;
      r.perr = bus.parity_err;
      r.ferr = bus.frame_err;
      got_q.push_back(r);
      checks++;
      if (valid_prev === 1'b1) begin
        errors++;
        $display("FAIL valid_width got 2+ cycles required 1 at %0t", $time);
      end
    end
    valid_prev = bus.valid;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] build_frame(input logic [7:0] b, input bit par_bad, input bit stop);
    logic [10:0] fr;
    fr      = '1;
    fr[0]   = 1'b0;
    fr[8:1] = b;
    if (PAR_EN) fr[9] = (^b) ^ par_bad;
    fr[NBITS-1] = stop;
    return fr;
  endfunction

  // what a correct receiver reports for a frame, straight from the frame rules
  function automatic rx_t model(input logic [10:0] fr);
    rx_t r;
    r.data = fr[8:1];
    r.perr = PAR_EN ? ^fr[9:1] : 1'b0;
    r.ferr = ~fr[NBITS-1];
    return r;
  endfunction

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_50M);
      bus.rxd = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop,
                            input int glitch, input int low_bits, input int gap_bits,
                            input int abort_at, output bit busy_mid);
    logic [10:0] fr;
    logic        lvl;
    fr       = build_frame(b, par_bad, stop);
    busy_mid = 1'b0;
    for (int i = 0; i < NBITS * BITC; i++) begin
      @(negedge clk_50M);
      if (i == abort_at) return;
      if (i == 5 * BITC) busy_mid = bus.busy;
      lvl = fr[i / BITC];
      if (i == glitch) lvl = ~lvl;
      bus.rxd = lvl;
    end
    for (int i = 0; i < low_bits * BITC; i++) begin
      @(negedge clk_50M);
      bus.rxd = 1'b0;
    end
    idle(gap_bits * BITC);
    #1;
  endtask

  task automatic expect_one(input string name, input rx_t exp);
    rx_t r;
    chk({name, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      chk({name, "_data"}, r.data, exp.data);
      chk({name, "_perr"}, r.perr, exp.perr);
      chk({name, "_ferr"}, r.ferr, exp.ferr);
    end
    got_q.delete();
  endtask

  vec_t vecs[7];

  initial begin
    bit  busy_mid;
    rx_t e;
    bus.rxd = 1'b1;
    reset   = 1'b1;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, -1, 0, 1, 8'hA5, 1'b0,   1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, -1, 0, 1, 8'h01, PAR_EN, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, -1, 3, 1, 8'h3C, 1'b0,   1'b1};
    vecs[3] = '{8'h7E, 1'b0, 1'b1, -1, 0, 1, 8'h7E, 1'b0,   1'b0};
    vecs[4] = '{8'h55, 1'b0, 1'b1, 3 * BITC + 35, 0, 1, 8'h55, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, -1, 0, 0, 8'h00, 1'b0,   1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, -1, 0, 1, 8'hFF, 1'b0,   1'b0};

    // reset state
    repeat (3) @(negedge clk_50M);
    #1;
    chk("rst_data", bus.data, 8'h00);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_perr", bus.parity_err, 1'b0);
    chk("rst_ferr", bus.frame_err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clk_50M);
    reset = 1'b0;
    idle(BITC);

    // table vectors
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].b, vecs[v].par_bad, vecs[v].stop, vecs[v].glitch,
                 vecs[v].low_bits, vecs[v].gap_bits, -1, busy_mid);
      chk($sformatf("vec%0d_busy_mid", v), busy_mid, 1'b1);
      e.data = vecs[v].exp_data;
      e.perr = vecs[v].exp_perr;
      e.ferr = vecs[v].exp_ferr;
      expect_one($sformatf("vec%0d", v), e);
      if (vecs[v].stop) chk($sformatf("vec%0d_busy_end", v), bus.busy, 1'b0);
    end

    // reset in data bit 4 of 0x96: outputs clear at once, no byte delivered
    send_frame(8'h96, 1'b0, 1'b1, -1, 0, 0, 5 * BITC + 20, busy_mid);
    reset = 1'b1;
    #1;
    chk("abort_data", bus.data, 8'h00);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_valid", bus.valid, 1'b0);
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk_50M);
    reset = 1'b0;
    idle(12 * BITC);
    #1;
    chk("abort_no_valid", got_q.size(), 0);
    got_q.delete();
    send_frame(8'h69, 1'b0, 1'b1, -1, 0, 1, -1, busy_mid);
    e = model(build_frame(8'h69, 1'b0, 1'b1));
    expect_one("after_abort", e);

    // 24-clock low glitch: start rejected, nothing delivered
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_50M);
      bus.rxd = 1'b0;
      if (i == 10) chk("glitch_busy_start", bus.busy, 1'b1);
    end
    idle(12 * BITC);
    #1;
    chk("glitch_no_valid", got_q.size(), 0);
    chk("glitch_busy_end", bus.busy, 1'b0);
    got_q.delete();

    // sustained break: exactly one all-zero byte with frame error
    for (int i = 0; i < 15 * BITC; i++) begin
      @(negedge clk_50M);
      bus.rxd = 1'b0;
    end
    #1;
    chk("break_busy", bus.busy, 1'b1);
    idle(2 * BITC);
    #1;
    e.data = 8'h00;
    e.perr = 1'b0;
    e.ferr = 1'b1;
    expect_one("break", e);
    chk("break_busy_end", bus.busy, 1'b0);

    // rxd low across reset release: no start until a real falling edge
    @(negedge clk_50M);
    bus.rxd = 1'b0;
    reset   = 1'b1;
    repeat (3) @(negedge clk_50M);
    reset = 1'b0;
    for (int i = 0; i < 12 * BITC; i++) begin
      @(negedge clk_50M);
      bus.rxd = 1'b0;
    end
    #1;
    chk("low_rst_no_valid", got_q.size(), 0);
    chk("low_rst_busy", bus.busy, 1'b0);
    got_q.delete();
    idle(BITC);
    send_frame(8'hC3, 1'b0, 1'b1, -1, 0, 1, -1, busy_mid);
    e = model(build_frame(8'hC3, 1'b0, 1'b1));
    expect_one("low_rst_next", e);

    // random frames against the frame-rule model
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      bit         pb, st;
      int         lowb, gap;
      b    = 8'($urandom);
      pb   = ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 5) != 0);
      lowb = st ? 0 : int'($urandom_range(0, 2));
      gap  = st ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(b, pb, st, -1, lowb, gap, -1, busy_mid);
      e = model(build_frame(b, pb, st));
      expect_one($sformatf("rand%0d", n), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
